// File: rtl/fifo_sync_pkg.sv
// Shared types and Gray/binary helpers for the async FIFO pointer synchronisers.
package fifo_sync_pkg;

    localparam int SYNC_STAGES_MAX = 4;
    localparam int PTR_W_MAX       = 32;

    typedef enum logic {
        FILL  = 1'b0,
        TRACK = 1'b1
    } sync_state_e;

    // Max-width helpers; zero-extended narrower codes decode correctly.
    function automatic logic [PTR_W_MAX-1:0] gray2bin(
        input logic [PTR_W_MAX-1:0] g
    );
        logic [PTR_W_MAX-1:0] b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_W_MAX-1:0] bin2gray(
        input logic [PTR_W_MAX-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/ptr_sync_gray_sync_chain.sv
// Plain N-flop synchroniser chain with asynchronous active-low reset.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ptr_sync_gray.sv
// Gray pointer synchroniser: sync chain, binary decode, advance/update/error.
module ptr_sync_gray
    import fifo_sync_pkg::*;
#(
    parameter int Addr_Width = 9,
    parameter int STAGES     = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic [Addr_Width:0] ptr_gray,
    input  logic                err_clr,
    output logic [Addr_Width:0] ptr_s,
    output logic [Addr_Width:0] ptr_bin,
    output logic [Addr_Width:0] ptr_delta,
    output logic                ptr_upd,
    output logic                ptr_err
);

    localparam int PW = Addr_Width + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {Addr_Width{1'b0}}};
    localparam logic [2:0] FILL_LAST = 3'(STAGES);

    if (STAGES < 2 || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("ptr_sync_gray: STAGES must be 2..4");
    end
    if (PW > PTR_W_MAX) begin : g_bad_width
        $error("ptr_sync_gray: pointer too wide");
    end

    sync_state_e   state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] delta_q, delta_d;
    logic          upd_q, upd_d;
    logic          err_q, err_d;

    sync_chain #(
        .WIDTH (PW),
        .STAGES(STAGES)
    ) u_chain (
        .clk  (wclk),
        .rst_n(wrst),
        .d    (ptr_gray),
        .q    (ptr_s)
    );

    assign bin_d = PW'(gray2bin(PTR_W_MAX'(ptr_s)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        delta_d = '0;
        upd_d   = 1'b0;
        err_d   = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        unique case (state_q)
            FILL: begin
                // Chain still carries reset zeros; no advance reporting yet.
                if (cnt_q == FILL_LAST) begin
                    state_d = TRACK;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            TRACK: begin
                delta_d = bin_d - bin_q;
                upd_d   = (bin_d != bin_q);
                if (delta_q > DEPTH) begin
                    err_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            bin_q   <= '0;
            delta_q <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            delta_q <= delta_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    assign ptr_bin   = bin_q;
    assign ptr_delta = delta_q;
    assign ptr_upd   = upd_q;
    assign ptr_err   = err_q;

endmodule

// File: tb/tb_ptr_sync_gray.sv
// Directed bench: 4-bit pointers, STAGES 2/3/4 instances on shared stimulus.
module tb_ptr_sync_gray;

    logic       wclk;
    logic       wrst;
    logic [3:0] ptr_gray;
    logic       err_clr;

    logic [3:0] s2, b2, dl2, s3, b3, dl3, s4, b4, dl4;
    logic       u2, e2, u3, e3, u4, e4;

    int checks = 0;
    int errors = 0;

    ptr_sync_gray #(.Addr_Width(3), .STAGES(2)) dut2 (
        .wclk(wclk), .wrst(wrst), .ptr_gray(ptr_gray), .err_clr(err_clr),
        .ptr_s(s2), .ptr_bin(b2), .ptr_delta(dl2), .ptr_upd(u2), .ptr_err(e2)
    );

    ptr_sync_gray #(.Addr_Width(3), .STAGES(3)) dut3 (
        .wclk(wclk), .wrst(wrst), .ptr_gray(ptr_gray), .err_clr(err_clr),
        .ptr_s(s3), .ptr_bin(b3), .ptr_delta(dl3), .ptr_upd(u3), .ptr_err(e3)
    );

    ptr_sync_gray #(.Addr_Width(3), .STAGES(4)) dut4 (
        .wclk(wclk), .wrst(wrst), .ptr_gray(ptr_gray), .err_clr(err_clr),
        .ptr_s(s4), .ptr_bin(b4), .ptr_delta(dl4), .ptr_upd(u4), .ptr_err(e4)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic go(input logic [3:0] g, input int n);
        ptr_gray = g;
        repeat (n) step();
    endtask

    initial begin
        wrst     = 1'b1;
        ptr_gray = 4'hA;
        err_clr  = 1'b0;
        #1 wrst  = 1'b0;
        #1;
        // reset state
        chk("rst_s2", s2, 0);
        chk("rst_b2", b2, 0);
        chk("rst_dl2", dl2, 0);
        chk("rst_u2", u2, 0);
        chk("rst_e2", e2, 0);
        chk("rst_b4", b4, 0);
        step();
        step();
        chk("rst_hold_s2", s2, 0);
        wrst = 1'b1;
        step();
        chk("fill1_b2", b2, 0);
        chk("fill1_u2", u2, 0);
        step();
        chk("fill2_s2", s2, 4'hA);
        chk("fill2_b2", b2, 0);
        step();
        chk("fill3_b2", b2, 4'hC);
        chk("fill3_u2", u2, 0);
        chk("fill3_dl2", dl2, 0);
        step();
        chk("fill4_u2", u2, 0);
        chk("fill4_dl2", dl2, 0);
        repeat (4) step();
        chk("fill_b4", b4, 4'hC);

        // single step and latency per STAGES
        go(4'b0000, 6);
        chk("idle_b2", b2, 0);
        chk("idle_u2", u2, 0);
        chk("idle_dl2", dl2, 0);
        ptr_gray = 4'b0001;
        step();
        chk("lat_k_s2", s2, 0);
        step();
        chk("lat_k1_s2", s2, 1);
        chk("lat_k1_s3", s3, 0);
        step();
        chk("lat_k2_b2", b2, 1);
        chk("lat_k2_dl2", dl2, 1);
        chk("lat_k2_u2", u2, 1);
        chk("lat_k2_s3", s3, 1);
        chk("lat_k2_s4", s4, 0);
        step();
        chk("lat_k3_u2", u2, 0);
        chk("lat_k3_dl2", dl2, 0);
        chk("lat_k3_s4", s4, 1);
        repeat (3) step();

        // wrap 15 -> 0
        go(4'b1100, 6);
        go(4'b1000, 6);
        chk("wrap_pre_b2", b2, 4'hF);
        chk("wrap_pre_e2", e2, 0);
        ptr_gray = 4'b0000;
        repeat (3) step();
        chk("wrap_b2", b2, 0);
        chk("wrap_dl2", dl2, 1);
        chk("wrap_u2", u2, 1);
        step();
        chk("wrap_e2", e2, 0);

        // full-depth jump legal, depth+1 illegal
        go(4'b0011, 6);
        ptr_gray = 4'b1111;
        repeat (3) step();
        chk("jump8_b2", b2, 4'hA);
        chk("jump8_dl2", dl2, 8);
        chk("jump8_u2", u2, 1);
        step();
        chk("jump8_e2", e2, 0);
        go(4'b0011, 6);
        chk("back8_e2", e2, 0);
        ptr_gray = 4'b1110;
        repeat (3) step();
        chk("jump9_b2", b2, 4'hB);
        chk("jump9_dl2", dl2, 9);
        chk("jump9_e2_early", e2, 0);
        step();
        chk("jump9_e2", e2, 1);
        repeat (3) step();
        chk("jump9_sticky_e2", e2, 1);
        chk("jump9_u2", u2, 0);

        // backwards move and err_clr priority
        go(4'b1000, 6);
        go(4'b0111, 6);
        chk("pre_clr_e2", e2, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_e2", e2, 0);
        ptr_gray = 4'b0110;
        repeat (3) step();
        chk("bwd_b2", b2, 4);
        chk("bwd_dl2", dl2, 4'hF);
        step();
        chk("bwd_e2", e2, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr2_e2", e2, 0);
        ptr_gray = 4'b0010;
        repeat (3) step();
        chk("bwd2_b2", b2, 3);
        chk("bwd2_dl2", dl2, 4'hF);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_vs_set_e2", e2, 1);

        // asynchronous reset mid-stream
        ptr_gray = 4'b0110;
        step();
        #2 wrst = 1'b0;
        #1;
        chk("arst_s2", s2, 0);
        chk("arst_b2", b2, 0);
        chk("arst_e2", e2, 0);
        chk("arst_s3", s3, 0);
        chk("arst_b3", b3, 0);
        chk("arst_s4", s4, 0);
        chk("arst_b4", b4, 0);
        step();
        wrst = 1'b1;
        step();
        chk("refill1_u2", u2, 0);
        step();
        chk("refill2_s2", s2, 4'b0110);
        step();
        chk("refill3_b2", b2, 4);
        chk("refill3_u2", u2, 0);
        chk("refill3_dl2", dl2, 0);
        step();
        chk("refill4_u2", u2, 0);
        step();
        chk("refill5_b4", b4, 4);
        chk("refill5_u4", u4, 0);
        chk("refill5_u3", u3, 0);
        chk("refill5_e2", e2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
